// File: rtl/line_buffer_3x3.sv
// 3x3 window column generator: two line memories turn a raster pixel stream
// into vertical triples (rows r-2, r-1, r) with one clock of latency.
module line_buffer_3x3 #(
    parameter logic [10:0] PIC_WIDTH  = 11'd250,
    parameter logic [10:0] PIC_HEIGHT = 11'd250,
    parameter int          WIDTH      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             sof,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             valid_out,
    output logic             frame_done
);

    localparam int AW = (PIC_WIDTH > 11'd1) ? $clog2(PIC_WIDTH) : 1;

    logic [WIDTH-1:0] line1_q [0:PIC_WIDTH-1];
    logic [WIDTH-1:0] line2_q [0:PIC_WIDTH-1];

    logic [10:0]      col_q, col_d, row_q, row_d;
    logic [10:0]      cur_col, cur_row;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] dout1_q, dout1_d, dout2_q, dout2_d, dout3_q, dout3_d;
    logic             valid_out_q, valid_out_d, frame_done_q, frame_done_d;

    always_comb begin
        cur_col      = col_q;
        cur_row      = row_q;
        col_d        = col_q;
        row_d        = row_q;
        dout1_d      = dout1_q;
        dout2_d      = dout2_q;
        dout3_d      = dout3_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;

        // A qualified sof relocates the current pixel to the frame origin.
        if (valid_in && sof) begin
            cur_col = 11'd0;
            cur_row = 11'd0;
        end
        addr = cur_col[AW-1:0];

        if (valid_in) begin
            dout3_d      = din;
            dout2_d      = line1_q[addr];
            dout1_d      = line2_q[addr];
            valid_out_d  = (cur_row >= 11'd2);
            frame_done_d = !sof && (cur_col == PIC_WIDTH - 11'd1)
                                && (cur_row == PIC_HEIGHT - 11'd1);
            if (cur_col == PIC_WIDTH - 11'd1) begin
                col_d = 11'd0;
                row_d = (cur_row == PIC_HEIGHT - 11'd1) ? 11'd0 : cur_row + 11'd1;
            end else begin
                col_d = cur_col + 11'd1;
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            dout1_q      <= '0;
            dout2_q      <= '0;
            dout3_q      <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            dout1_q      <= dout1_d;
            dout2_q      <= dout2_d;
            dout3_q      <= dout3_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line memories are never reset; the row >= 2 gate keeps stale data off valid outputs.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            line1_q[addr] <= din;
            line2_q[addr] <= line1_q[addr];
        end
    end

    assign dout1      = dout1_q;
    assign dout2      = dout2_q;
    assign dout3      = dout3_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/line_buffer_3x3.md
LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 Parameter PIC_WIDTH, default 11'd250, pixels per image row (legal range 3..2047).
REQ-002 Parameter PIC_HEIGHT, default 11'd250, rows per frame (legal range 3..2047).
REQ-003 Parameter WIDTH, default 24, pixel data width (RGB888).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port valid_in  input  1  din carries an accepted pixel this cycle.
REQ-007 Port sof  input  1  start of frame; qualified by valid_in, marks pixel (row 0, col 0).
REQ-008 Port din  input  WIDTH  raster-order pixel stream.
REQ-009 Port dout1  output  WIDTH  pixel from row r-2 (top row of window column).
REQ-010 Port dout2  output  WIDTH  pixel from row r-1 (middle row).
REQ-011 Port dout3  output  WIDTH  pixel from row r (current row, bottom).
REQ-012 Port valid_out  output  1  dout1..dout3 form a valid vertical column triple.
REQ-013 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 Block SHALL contain two line memories, line1 (row r-1) and line2 (row r-2), each PIC_WIDTH x WIDTH, contents not reset.
REQ-015 Column counter col (11 bit) SHALL increment on each valid_in, wrap PIC_WIDTH-1 -> 0; row counter row (11 bit) SHALL increment on col wrap, wrap PIC_HEIGHT-1 -> 0.
REQ-016 On valid_in at column c, next edge SHALL set dout3<=din, dout2<=line1[c], dout1<=line2[c], and write line1[c]<=din, line2[c]<=old line1[c] (read-before-write, same cycle).
REQ-017 Latency din -> dout3 SHALL be exactly 1 clock; dout1/dout2 at same edge as their dout3 partner.
REQ-018 valid_out SHALL be registered: valid_out <= valid_in AND (row >= 2), evaluated with row before update.
REQ-019 When valid_in = 0, dout1..dout3 SHALL hold, counters SHALL hold, memories SHALL not be written, valid_out SHALL be 0.
REQ-020 Gaps in valid_in mid-row SHALL not corrupt column alignment; col resumes from held value.
REQ-021 sof AND valid_in SHALL force the pixel to col 0, row 0 (counters restart: next col=1, row=0), overriding any count in progress.
REQ-022 sof without valid_in SHALL be ignored.
REQ-023 frame_done SHALL pulse 1 cycle, registered, when valid_in accepts col=PIC_WIDTH-1, row=PIC_HEIGHT-1; 0 otherwise.
REQ-024 Simultaneous sof and end-of-frame position: sof wins, frame_done SHALL stay 0.
REQ-025 Rows 0 and 1 of each frame SHALL be written to memories but produce valid_out = 0; first valid_out on row 2, col 0.
REQ-026 Across frame wrap, memory contents from prior frame SHALL be ignored because row restarts at 0 (valid_out gated).

Reset
REQ-027 rst = 1 SHALL asynchronously clear dout1, dout2, dout3 to 0, valid_out and frame_done to 0, col and row to 0.
REQ-028 rst asserted mid-frame SHALL discard the frame; after release the next accepted pixel is treated as row 0, col 0.
REQ-029 Line memories SHALL not be reset; no output may depend on unwritten memory while valid_out = 1.

Verification (PIC_WIDTH=4, PIC_HEIGHT=4, pixel = {3{row*16+col}})
REQ-030 Continuous frame, valid_in=1 -> valid_out low for 8 pixels, then row 2 col 0 yields dout1=0x000000, dout2=0x101010, dout3=0x202020.
REQ-031 Last pixel (row 3, col 3) -> dout1=0x131313, dout2=0x232323, dout3=0x333333, frame_done=1 one cycle later, exactly one pulse.
REQ-032 valid_in deasserted 3 cycles between row 2 col 1 and col 2 -> outputs hold 0x212121 triple, valid_out=0 during gap, col 2 triple correct after.
REQ-033 sof re-asserted at row 2 col 1 -> next 8 pixels valid_out=0, no frame_done; new frame rows align correctly.
REQ-034 rst pulsed during row 3 -> all outputs 0 immediately (async), next frame from sof behaves as REQ-030.
REQ-035 Back-to-back frames with no idle cycle -> second frame valid_out starts at its row 2, col 0; no prior-frame data appears on valid outputs.
